stream_upsizer: RTL

//  Valid/ready width up-converter. Packs RATIO narrow beats of IN_WIDTH bits into one

---
 rtl/stream_pkg.sv | 14 +
 rtl/stream_upsizer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/stream_pkg.sv
// Shared stream types: upsizer FSM state and the logical-to-physical lane mapping.
package stream_pkg;

    typedef enum logic {
        UPS_FILL = 1'b0,
        UPS_HOLD = 1'b1
    } ups_state_e;

    // Physical lane for logical beat idx; MSB-first mirrors beat 0 into the top lane.
    function automatic int ups_lane(input int idx, input int ratio, input bit msb_first);
        return msb_first ? (ratio - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Valid/ready width up-converter: packs RATIO beats of IN_WIDTH bits into one registered word.
// Optional packet framing (last_i/last_o, early word close) is built with STREAM_UPSIZER_LAST_EN.
module stream_upsizer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            flush_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [IN_WIDTH-1:0]             data_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [IN_WIDTH*RATIO-1:0]       data_o,
    output logic [$clog2(RATIO+1)-1:0]      cnt_o,
`ifdef STREAM_UPSIZER_LAST_EN
    input  logic                            last_i,
    output logic                            last_o,
`endif
    output logic                            dbg_state_o
);

    localparam int CW = $clog2(RATIO + 1);
    localparam int OW = IN_WIDTH * RATIO;

    ups_state_e      st_q;
    logic [CW-1:0]   cnt_q;
    logic [OW-1:0]   data_q;
    logic            valid_q;

    logic            in_hs;
    logic            out_hs;
    logic            close_word;
    logic [CW-1:0]   base_cnt;
    logic [CW-1:0]   inc_cnt;
    logic [OW-1:0]   packed_d;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // once valid_o is raised, data_o/cnt_o/last_o hold until that transfer (or a flush).
    assign ready_o = !flush_i && ((st_q == UPS_FILL) || ready_i);
    assign in_hs   = valid_i && ready_o;
    assign out_hs  = valid_q && ready_i;

    // A beat taken while draining a held word starts the next word at beat 0.
    assign base_cnt = (st_q == UPS_HOLD) ? '0 : cnt_q;
    assign inc_cnt  = base_cnt + CW'(1);

`ifdef STREAM_UPSIZER_LAST_EN
    assign close_word = (inc_cnt == CW'(RATIO)) || last_i;
`else
    assign close_word = (inc_cnt == CW'(RATIO));
`endif

    // Beat 0 starts from an all-zero word so unused lanes of a short word read 0.
    always_comb begin
        packed_d = (base_cnt == '0) ? '0 : data_q;
        for (int l = 0; l < RATIO; l++) begin
            if (ups_lane(int'(base_cnt), RATIO, MSB_FIRST) == l) begin
                packed_d[l*IN_WIDTH +: IN_WIDTH] = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q    <= UPS_FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            st_q    <= UPS_FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (st_q)
                UPS_FILL: begin
                    if (in_hs) begin
                        data_q <= packed_d;
                        cnt_q  <= inc_cnt;
                        if (close_word) begin
                            st_q    <= UPS_HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                UPS_HOLD: begin
                    if (out_hs) begin
                        if (in_hs) begin
                            data_q  <= packed_d;
                            cnt_q   <= inc_cnt;
                            st_q    <= close_word ? UPS_HOLD : UPS_FILL;
                            valid_q <= close_word;
                        end else begin
                            cnt_q   <= '0;
                            st_q    <= UPS_FILL;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    st_q    <= UPS_FILL;
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef STREAM_UPSIZER_LAST_EN
    logic last_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b0;
        end else if (flush_i) begin
            last_q <= 1'b0;
        end else if ((st_q == UPS_FILL) && in_hs && close_word) begin
            last_q <= last_i;
        end else if ((st_q == UPS_HOLD) && out_hs) begin
            last_q <= in_hs && close_word && last_i;
        end
    end

    assign last_o = last_q;
`endif

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign cnt_o       = cnt_q;
    assign dbg_state_o = st_q;

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk_i) (RATIO >= 2) && (IN_WIDTH >= 1));

    a_no_flush_with_valid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(flush_i && valid_i));

    a_output_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (valid_q && !ready_i && !flush_i) |=> (valid_q && $stable(data_q) && $stable(cnt_q)));
`endif

endmodule
